// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Opcodes, FSM state encoding and datapath width.
package hilo_muldiv_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int ITER   = 32;
  localparam int CNT_W  = $clog2(ITER);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// EX-stage request/response bundle for the HI/LO sequencer.
// The pipeline side drives requests; the sequencer drives status and HI/LO.
interface hilo_muldiv_sequencer_if;
  import hilo_muldiv_sequencer_pkg::*;
  logic              Start_in;
  logic [2:0]        Op_in;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic              ReadHiLo_in;
  logic              Busy_out;
  logic              Stall_out;
  logic              Done_out;
  logic              DivByZero_out;
  logic [DATA_W-1:0] Hi_out;
  logic [DATA_W-1:0] Lo_out;

  modport master (
    output Start_in, Op_in, A_in, B_in, ReadHiLo_in,
    input  Busy_out, Stall_out, Done_out, DivByZero_out,
    input  Hi_out, Lo_out
  );

  modport slave (
    input  Start_in, Op_in, A_in, B_in, ReadHiLo_in,
    output Busy_out, Stall_out, Done_out, DivByZero_out,
    output Hi_out, Lo_out
  );
endinterface

// File: rtl/hilo_muldiv_sequencer_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide.
// Multiply leaves {hi,lo} = product; divide leaves hi = rem, lo = quot.
module muldiv_iter_core
  import hilo_muldiv_sequencer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_last_step
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_div;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;

  assign w_sum  = {1'b0, r_hi} + ({(DATA_W+1){r_lo[0]}} & {1'b0, r_b});
  assign w_sh   = {r_hi, r_lo[DATA_W-1]};
  assign w_ge   = w_sh >= {1'b0, r_b};
  assign w_diff = w_sh - {1'b0, r_b};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
      r_div <= i_div;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        r_hi <= w_ge ? w_diff[DATA_W-1:0] : w_sh[DATA_W-1:0];
        r_lo <= {r_lo[DATA_W-2:0], w_ge};
      end else begin
        r_hi <= w_sum[DATA_W:1];
        r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
      end
    end
  end

  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_last_step = i_step && (r_cnt == LAST);
endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner for EX: sequences MUL/DIV/MADD/MSUB, MTHI/MTLO writes,
// and stalls the pipeline while a HI/LO result is pending.
module hilo_muldiv_sequencer
  import hilo_muldiv_sequencer_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Rst,
  hilo_muldiv_sequencer_if.slave  bus
);
  state_e            r_state, w_next;
  op_e               r_op, w_op;
  logic              r_sa, r_sb;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic              r_done, r_dbz;

  logic              w_idle, w_iter_op, w_div_op, w_signed;
  logic              w_dz, w_acc, w_step, w_last;
  logic [DATA_W-1:0] w_ua, w_ub, w_c_hi, w_c_lo, w_q, w_r;
  logic [2*DATA_W-1:0] w_prod, w_sprod, w_res;

  assign w_op      = op_e'(bus.Op_in);
  assign w_idle    = (r_state == S_IDLE);
  assign w_div_op  = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_iter_op = (w_op != OP_MTHI) && (w_op != OP_MTLO);
  assign w_signed  = (w_op != OP_MULTU) && (w_op != OP_DIVU);
  assign w_dz      = w_div_op && (bus.B_in == '0);
  assign w_acc     = w_idle && bus.Start_in && w_iter_op && !w_dz;
  assign w_step    = (r_state == S_RUN);
  assign w_ua = (w_signed && bus.A_in[DATA_W-1]) ? -bus.A_in : bus.A_in;
  assign w_ub = (w_signed && bus.B_in[DATA_W-1]) ? -bus.B_in : bus.B_in;

  muldiv_iter_core u_core (
    .i_clk       (Clk),
    .i_rst       (Rst),
    .i_load      (w_acc),
    .i_step      (w_step),
    .i_div       (w_div_op),
    .i_a         (w_ua),
    .i_b         (w_ub),
    .o_hi        (w_c_hi),
    .o_lo        (w_c_lo),
    .o_last_step (w_last)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Core works on magnitudes; signs are restored here at FIX
  always_comb begin
    w_prod  = {w_c_hi, w_c_lo};
    w_sprod = (r_sa ^ r_sb) ? -w_prod : w_prod;
    w_q     = (r_sa ^ r_sb) ? -w_c_lo : w_c_lo;
    w_r     = r_sa ? -w_c_hi : w_c_hi;
    w_res   = w_sprod;
    unique case (r_op)
      OP_DIV, OP_DIVU: w_res = {w_r, w_q};
      OP_MADD:         w_res = {r_hi, r_lo} + w_sprod;
      OP_MSUB:         w_res = {r_hi, r_lo} - w_sprod;
      default:         w_res = w_sprod;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_MULT;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      if (w_acc) begin
        r_op <= w_op;
        r_sa <= w_signed && bus.A_in[DATA_W-1];
        r_sb <= w_signed && bus.B_in[DATA_W-1];
      end
      if (r_state == S_FIX) begin
        {r_hi, r_lo} <= w_res;
        r_done       <= 1'b1;
      end else if (w_idle && bus.Start_in && !w_acc) begin
        if (w_op == OP_MTHI) r_hi <= bus.A_in;
        if (w_op == OP_MTLO) r_lo <= bus.A_in;
        r_done <= 1'b1;
        r_dbz  <= w_dz;
      end
    end
  end

  assign bus.Busy_out      = !w_idle;
  assign bus.Stall_out     = !w_idle && (bus.Start_in || bus.ReadHiLo_in);
  assign bus.Done_out      = r_done;
  assign bus.DivByZero_out = r_dbz;
  assign bus.Hi_out        = r_hi;
  assign bus.Lo_out        = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Self-checking bench for hilo_muldiv_sequencer: vector table,
// hand-written stall/reset sequences and randomized model comparison.
module tb_hilo_muldiv_sequencer;
  import hilo_muldiv_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer_if bus ();

  hilo_muldiv_sequencer dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a, b,
                                output logic dz);
    int    sa, sb;
    longint p;
    logic [63:0] acc;
    sa = a;
    sb = b;
    dz = 1'b0;
    acc = {m_hi, m_lo};
    p = longint'(sa) * longint'(sb);
    case (op)
      3'd0: acc = p;
      3'd1: acc = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          acc = {32'd0, 32'h8000_0000};
        else acc = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) dz = 1'b1;
        else acc = {a % b, a / b};
      end
      3'd4: acc[63:32] = a;
      3'd5: acc[31:0] = a;
      3'd6: acc = acc + p;
      default: acc = acc - p;
    endcase
    {m_hi, m_lo} = acc;
  endfunction

  function automatic int exp_lat(input logic [2:0] op,
                                 input logic [31:0] b);
    if (op == 3'd4 || op == 3'd5) return 0;
    if ((op == 3'd2 || op == 3'd3) && b == 0) return 0;
    return ITER + 1;
  endfunction

  // Start pulse at edge 0; lat = index of the edge after which Done is seen
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b,
                       output int lat, output logic dz);
    @(negedge clk);
    bus.Start_in = 1'b1;
    bus.Op_in    = op;
    bus.A_in     = a;
    bus.B_in     = b;
    @(posedge clk); #1;
    bus.Start_in = 1'b0;
    lat = 0;
    while (!bus.Done_out && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    dz = bus.DivByZero_out;
    if (lat >= 60) begin
      errors++;
      $display("FAIL timeout op=%0d", op);
    end
  endtask

  vec_t vt[12];
  int   lat, nstall, nbusy, cyc;
  logic dz, mdz, sawdone;

  initial begin
    bus.Start_in    = 1'b0;
    bus.Op_in       = 3'd0;
    bus.A_in        = '0;
    bus.B_in        = '0;
    bus.ReadHiLo_in = 1'b0;

    vt[0]  = '{3'd4, 32'h11, 32'h0, 32'h11, 32'h0, 1'b0};
    vt[1]  = '{3'd5, 32'h22, 32'h0, 32'h11, 32'h22, 1'b0};
    vt[2]  = '{3'd3, 32'd100, 32'h0, 32'h11, 32'h22, 1'b1};
    vt[3]  = '{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vt[4]  = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[5]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0};
    vt[6]  = '{3'd4, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFC, 1'b0};
    vt[7]  = '{3'd5, 32'h5, 32'h0, 32'h0, 32'h5, 1'b0};
    vt[8]  = '{3'd6, 32'd2, 32'd3, 32'h0, 32'hB, 1'b0};
    vt[9]  = '{3'd7, 32'd4, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[10] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
    vt[11] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", bus.Hi_out, 0);
    chk("reset_lo", bus.Lo_out, 0);
    chk("reset_busy", bus.Busy_out, 0);
    chk("reset_done", bus.Done_out, 0);
    chk("reset_dbz", bus.DivByZero_out, 0);
    chk("reset_stall", bus.Stall_out, 0);

    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, lat, dz);
      chk($sformatf("vec%0d_hi", i), bus.Hi_out, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.Lo_out, vt[i].lo);
      chk($sformatf("vec%0d_dz", i), dz, vt[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, exp_lat(vt[i].op, vt[i].b));
      if (vt[i].dz) chk($sformatf("vec%0d_busy", i), bus.Busy_out, 0);
    end
    m_hi = bus.Hi_out;
    m_lo = bus.Lo_out;

    // Busy must span exactly ITER+1 cycles for an iterative op
    @(negedge clk);
    bus.Start_in = 1'b1; bus.Op_in = 3'd0; bus.A_in = 32'd9; bus.B_in = 32'd9;
    @(posedge clk); #1;
    bus.Start_in = 1'b0;
    nbusy = 0;
    while (bus.Busy_out && nbusy < 60) begin
      @(posedge clk); #1;
      nbusy++;
    end
    chk("busy_len", nbusy, ITER + 1);
    chk("busy_done", bus.Done_out, 1);
    chk("busy_lo", bus.Lo_out, 81);

    // Start with read in IDLE: no stall, read sees pre-edge HI
    @(negedge clk);
    bus.Start_in = 1'b1; bus.Op_in = 3'd4; bus.A_in = 32'hABCD;
    bus.ReadHiLo_in = 1'b1;
    #1;
    chk("idle_stall", bus.Stall_out, 0);
    chk("idle_hi_pre", bus.Hi_out, 0);
    @(posedge clk); #1;
    bus.Start_in = 1'b0; bus.ReadHiLo_in = 1'b0;
    chk("idle_hi_post", bus.Hi_out, 32'hABCD);

    // Held MFHI and Start during a MULTU
    @(negedge clk);
    bus.Start_in = 1'b1; bus.Op_in = 3'd1;
    bus.A_in = 32'h1_0000; bus.B_in = 32'h1_0000;
    @(posedge clk); #1;
    bus.Start_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.Start_in = 1'b1; bus.Op_in = 3'd5; bus.A_in = 32'h55;
    bus.ReadHiLo_in = 1'b1;
    nstall = 0;
    @(negedge clk);
    while (bus.Stall_out && nstall < 60) begin
      nstall++;
      @(negedge clk);
    end
    chk("stall_len", nstall, ITER - 3);
    chk("stall_busy", bus.Busy_out, 0);
    chk("mfhi_fresh", bus.Hi_out, 1);
    chk("mflo_fresh", bus.Lo_out, 0);
    @(posedge clk); #1;
    bus.Start_in = 1'b0; bus.ReadHiLo_in = 1'b0;
    chk("held_done", bus.Done_out, 1);
    chk("held_lo", bus.Lo_out, 32'h55);

    // Reset mid-divide discards the operation
    do_op(3'd5, 32'd9, 32'd0, lat, dz);
    chk("mtlo9", bus.Lo_out, 9);
    @(negedge clk);
    bus.Start_in = 1'b1; bus.Op_in = 3'd2; bus.A_in = 32'd100; bus.B_in = 32'd7;
    @(posedge clk); #1;
    bus.Start_in = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_hi", bus.Hi_out, 0);
    chk("rst_lo", bus.Lo_out, 0);
    chk("rst_busy", bus.Busy_out, 0);
    @(negedge clk);
    rst = 1'b0;
    sawdone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      sawdone |= bus.Done_out;
    end
    chk("rst_nodone", sawdone, 0);
    do_op(3'd0, 32'd6, 32'd7, lat, dz);
    chk("post_rst_lo", bus.Lo_out, 42);
    chk("post_rst_hi", bus.Hi_out, 0);

    m_hi = bus.Hi_out;
    m_lo = bus.Lo_out;
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      cyc = $urandom_range(0, 7);
      if (cyc == 0) b = 0;
      if (cyc == 1) a = 32'h8000_0000;
      if (cyc == 2) b = 32'hFFFF_FFFF;
      if (cyc == 3) b = 32'($urandom_range(1, 9));
      model(op, a, b, mdz);
      do_op(op, a, b, lat, dz);
      chk($sformatf("rnd%0d_hi", n), bus.Hi_out, m_hi);
      chk($sformatf("rnd%0d_lo", n), bus.Lo_out, m_lo);
      chk($sformatf("rnd%0d_dz", n), dz, mdz);
      chk($sformatf("rnd%0d_lat", n), lat, exp_lat(op, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle controller that owns the HI/LO register pair for the execute stage.
- Sequences iterative multiply and divide over 32 cycles and handles direct HI/LO writes.
- Raises a pipeline stall while HI/LO results are pending.
- Sits beside the ALU in EX: operands come from the forwarded Rs/Rt values, and its HI/LO outputs feed the MFHI/MFLO path.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- ITER, 32, shift iterations per MUL/DIV; must equal DATA_W.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous active-high reset
- Start_in  in  1  op request valid this cycle
- Op_in  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- A_in  in  32  Rs operand (dividend / multiplicand / MTHI/MTLO data)
- B_in  in  32  Rt operand (divisor / multiplier)
- ReadHiLo_in  in  1  MFHI/MFLO present in EX this cycle
- Busy_out  out  1  iterative op in progress
- Stall_out  out  1  freeze IF/ID/EX this cycle
- Done_out  out  1  one-cycle pulse: HI/LO updated at this edge
- DivByZero_out  out  1  one-cycle pulse: DIV/DIVU with B_in=0
- Hi_out  out  32  current HI
- Lo_out  out  32  current LO

Behaviour:
- Reset: HI=LO=0, state IDLE, Busy/Done/DivByZero=0. Rst mid-operation aborts; no partial HI/LO write.
- States: IDLE, RUN, FIX.
  - IDLE + Start_in + op in {MULT, MULTU, DIV, DIVU, MADD, MSUB}, with B≠0 for a divide: latch |A| and |B| (signed ops) or raw A and B (unsigned ops), latch the sign bits, count=0, go to RUN.
  - RUN: one shift-add (mul) or one restoring shift-subtract (div) step per cycle. After the ITER-th step go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse Done_out, go to IDLE.
- Latency: start accepted at edge 0; HI/LO hold the new value after edge ITER+1 (33). Busy_out is high from edge 0 through the FIX cycle.
- MTHI/MTLO accepted in IDLE: write at that edge, no state change, Done_out pulses, latency 1.
- DIV/DIVU with B_in=0 in IDLE: HI/LO unchanged, DivByZero_out and Done_out pulse at that edge, stay IDLE.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - MADD/MSUB: {HI,LO} ± signed 64-bit product, modulo 2^64, using HI/LO as they stand at FIX.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide: quotient sign = sA^sB, remainder sign = sA (truncation toward zero).
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- Stall_out = Busy_out & (Start_in | ReadHiLo_in), combinational.
  - A Start_in while busy is ignored. The pipeline holds it, and it is accepted the cycle after FIX.
  - The cycle after FIX, Busy=0, so a held MFHI reads the fresh value.
- IDLE with Start_in and ReadHiLo_in in the same cycle: no stall; the read sees pre-edge HI/LO.
- Hi_out/Lo_out are registered outputs and never show intermediate RUN values.

Decomposition:
- Shared package: opcode constants (OP_MULT..OP_MSUB), state encoding (S_IDLE, S_RUN, S_FIX), DATA_W.
- One sub-module is natural: muldiv_iter_core.
  - Contents: datapath registers for product/remainder, quotient/multiplier and the iteration counter.
  - Control lines: load, step, and a mode select.
  - It reports last_step to the sequencer FSM.
- HI/LO registers, sign fixup and the stall logic stay in the top.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 → Busy high 33 cycles, Done at edge 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands → LO=0x7FFFFFFC, HI=1.
- DIVU A=100, B=0 with HI=0x11, LO=0x22 → DivByZero_out and Done_out pulse at the same edge, HI/LO unchanged, Busy stays 0.
- MTHI 0, MTLO 5, then MADD A=2, B=3 → HI=0, LO=0x0000000B. MSUB A=4, B=3 → LO=0xFFFFFFFF, HI=0xFFFFFFFF.
- MULTU 0x10000 × 0x10000 with ReadHiLo_in and a second Start_in asserted at cycle 5 → Stall_out high cycles 5–33, second op starts at cycle 34, MFHI returns 1.
- Assert Rst at cycle 10 of a DIV after MTLO 9 → HI=LO=0, Busy=0, no Done pulse. A subsequent MULT 6×7 → LO=42.
